grid_renderer: RTL and testbench
================================

# grid_renderer

Clocked, parametrised successor to the combinational playfield colour mapper. Tracks the raster position incrementally instead of dividing DrawX/DrawY, and looks up each cell's value in an 8-entry palette. Can flash rows flagged for clearing. Drives registered 4:4:4 RGB to the HDMI encoder path with a fixed pipeline latency; the VGA/HDMI timing generator supplies DrawX/DrawY once per pixel clock.

## Interface
Parameters:
- COLS, 10, playfield columns
- ROWS, 20, playfield rows
- CELL, 24, cell pitch in pixels (2..64); pixel 0 of each cell is grid line
- X0, 200, left edge of playfield in pixels
- Y0, 0, top edge of playfield in pixels
- FLASH_SHIFT, 3, flash half-period is 2^FLASH_SHIFT frames

Ports:
- Clk  in  1  pixel clock; one DrawX step per cycle
- Reset_n  in  1  asynchronous, active-low reset
- DrawX  in  10  current pixel column, increments by 1 per Clk within a line
- DrawY  in  10  current pixel row
- frame_start  in  1  one-cycle pulse at the start of each frame
- grid  in  3×COLS×ROWS  cell values, indexed grid[col][row]; 0 = empty
- clear_mask  in  ROWS  bit r set = row r pending clear
- Red, Green, Blue  out  4 each  registered pixel colour

## Operation
- Region: the playfield is X0 ≤ DrawX < X0+COLS·CELL and Y0 ≤ DrawY < Y0+ROWS·CELL. Outside it, output black (0,0,0).
- Column tracking, no dividers:
  - When DrawX == X0: sub-x counter sx ← 0, column cx ← 0.
  - Otherwise, inside the region: sx increments; at sx == CELL-1, sx wraps to 0 and cx increments.
- Row tracking, updated on the DrawX == 0 cycle:
  - If DrawY == Y0: sy ← 0, ry ← 0.
  - Otherwise, if inside the vertical range: sy increments and wraps at CELL-1, with ry incrementing on the wrap.
  - cx and ry saturate at COLS-1 and ROWS-1; they never index out of range.
- Pixel colour:
  - Grid line (sx == 0 or sy == 0): black.
  - Otherwise palette[grid[cx][ry]]:
    - 0 white FFF
    - 1 cyan 0FF
    - 2 yellow FF0
    - 3 purple A0F
    - 4 green 0F0
    - 5 red F00
    - 6 blue 00F
    - 7 orange F80
- Right border: the pixel at DrawX == X0+COLS·CELL is a black grid line, closing the frame.
- Flash: a frame counter fcnt increments on each frame_start pulse and wraps freely. Phase = fcnt[FLASH_SHIFT]. While phase == 1, non-line pixels in rows with clear_mask[ry] set render white.
- Sampling rules:
  - grid and clear_mask are sampled in pipeline stage 1.
  - Changes mid-frame take effect on the next pixel processed.

## Timing
- Pipeline:
  - Stage 0: counters updated from DrawX/DrawY.
  - Stage 1: region/line flags, cell value and flash decision registered.
  - Stage 2: palette lookup registered onto Red/Green/Blue.
- Latency: the colour for a given (DrawX, DrawY) appears exactly 2 Clk cycles after that pair is presented. The timing generator delays hsync/vsync/de by 2 to match.
- Reset (asynchronous, Reset_n low):
  - Red, Green, Blue = 0.
  - sx, cx, sy, ry, fcnt = 0; pipeline valid flags cleared.
  - Output stays black until the pipeline refills 2 cycles after release.
- Reset mid-frame: counters stay at 0, so pixels are wrong until the next DrawX == X0 (columns) and DrawY == Y0 (rows) resynchronise them. No lock-up.
- frame_start coinciding with a row update: both apply in the same cycle, independently.
- fcnt wraps from all-ones to 0 with no glitch beyond a normal phase flip.

## Configuration
- GRID_FLASH_EN defined: fcnt and the clear_mask flash path are built as described.
- GRID_FLASH_EN undefined:
  - fcnt is removed and the flash condition is constant 0.
  - clear_mask and frame_start are ignored.
  - Latency stays 2 cycles.

## Test plan
All scenarios use default parameters.
- Reset: hold Reset_n low mid-line with arbitrary DrawX/DrawY → RGB = 000 immediately. After release, first valid colour appears 2 cycles after the first presented pixel.
- Empty grid, sweep line DrawY=30:
  - DrawX=200 → 000 at +2 cycles; DrawX=201 → FFF; DrawX=224 → 000; DrawX=440 → 000; DrawX=441 → 000.
  - DrawX=199 → 000 (outside region).
- Cell lookup: grid[3][1]=5 with all other cells 0. Line DrawY=30:
  - DrawX=273..295 → F00.
  - DrawX=272 and DrawX=296 → 000.
  - DrawX=297 → FFF.
- Row tracking: grid[0][19]=2. Line DrawY=470, DrawX=210 → FF0. Line DrawY=456, DrawX=210 → 000 (grid line).
- Flash (GRID_FLASH_EN): grid[0][0]=1, clear_mask[0]=1.
  - Frames 0-7 at DrawX=210, DrawY=10 → 0FF.
  - Frames 8-15 → FFF.
  - Frame 16 → 0FF.
  - With the macro undefined, every frame → 0FF.
- Latency check: random grid contents with a full-frame sweep compared against a reference model delayed 2 cycles → zero mismatches.

Source files
------------

// File: rtl/grid_renderer.sv
// -----------------------------------------------------------------------------
// grid_renderer
//
// Clocked playfield colour mapper. Tracks the raster position incrementally
// (no dividers) and maps each playfield cell value through an 8-entry
// palette to registered 4:4:4 RGB. The latency from a DrawX/DrawY pair to its
// colour is exactly 2 Clk cycles.
//
// Pipeline
//   stage 0 : sub-cell / cell counters advanced from DrawX/DrawY
//             (combinational, written back to the counter flops)
//   stage 1 : region flag, grid-line flag, cell value and flash decision
//   stage 2 : palette lookup registered onto Red/Green/Blue
//
// Optional feature macro: GRID_FLASH_EN
//   defined   : frame counter fcnt plus the clear_mask row-flash path
//   undefined : no frame counter, flash is constant 0, clear_mask and
//               frame_start are ignored (latency unchanged)
//
// Ports
//   Clk          in   pixel clock, one DrawX step per cycle
//   Reset_n      in   asynchronous active-low reset
//   DrawX        in   [9:0] current pixel column
//   DrawY        in   [9:0] current pixel row
//   frame_start  in   one-cycle pulse at the start of each frame
//   grid         in   [3*COLS*ROWS-1:0] cell values; cell (col,row) lives at
//                     bits [(col*ROWS+row)*3 +: 3]; 0 = empty
//   clear_mask   in   [ROWS-1:0] bit r set = row r pending clear
//   Red/Green/Blue out [3:0] each, registered pixel colour
// -----------------------------------------------------------------------------
module grid_renderer #(
    parameter int COLS        = 10,
    parameter int ROWS        = 20,
    parameter int CELL        = 24,
    parameter int X0          = 200,
    parameter int Y0          = 0,
    parameter int FLASH_SHIFT = 3
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic                     frame_start,
    input  logic [3*COLS*ROWS-1:0]   grid,
    input  logic [ROWS-1:0]          clear_mask,
    output logic [3:0]               Red,
    output logic [3:0]               Green,
    output logic [3:0]               Blue
);

    localparam int SXW = $clog2(CELL);
    localparam int CXW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RYW = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Region bounds carried at 11 bits so X0 + COLS*CELL may reach 1024.
    localparam logic [10:0] X_BEG = 11'(X0);
    localparam logic [10:0] X_END = 11'(X0 + COLS * CELL);
    localparam logic [10:0] Y_BEG = 11'(Y0);
    localparam logic [10:0] Y_END = 11'(Y0 + ROWS * CELL);

    localparam logic [SXW-1:0] SUB_LAST = SXW'(CELL - 1);
    localparam logic [CXW-1:0] CX_LAST  = CXW'(COLS - 1);
    localparam logic [RYW-1:0] RY_LAST  = RYW'(ROWS - 1);

    // ------------------------------------------------------------------
    // Cell array view of the flat grid bus
    // ------------------------------------------------------------------
    logic [2:0] cell_arr [COLS][ROWS];

    genvar gi, gj;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_col
            for (gj = 0; gj < ROWS; gj++) begin : g_row
                assign cell_arr[gi][gj] = grid[(gi * ROWS + gj) * 3 +: 3];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 0: raster counters
    // ------------------------------------------------------------------
    logic [10:0]    dx_w, dy_w;
    logic           in_x, in_y;
    logic [SXW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [CXW-1:0] cx_q, cx_d;
    logic [RYW-1:0] ry_q, ry_d;

    assign dx_w = {1'b0, DrawX};
    assign dy_w = {1'b0, DrawY};
    assign in_x = (dx_w >= X_BEG) && (dx_w < X_END);
    assign in_y = (dy_w >= Y_BEG) && (dy_w < Y_END);

    // The _d values describe the pixel presented this cycle; they feed
    // stage 1 directly so the pixel at DrawX == X0 already sees sx == 0.
    always_comb begin
        sx_d = sx_q;
        cx_d = cx_q;
        if (dx_w == X_BEG) begin
            sx_d = '0;
            cx_d = '0;
        end else if (in_x) begin
            if (sx_q == SUB_LAST) begin
                sx_d = '0;
                if (cx_q != CX_LAST) begin
                    cx_d = cx_q + CXW'(1);
                end
            end else begin
                sx_d = sx_q + SXW'(1);
            end
        end
    end

    // Rows advance once per line, on the DrawX == 0 cycle.
    always_comb begin
        sy_d = sy_q;
        ry_d = ry_q;
        if (dx_w == 11'd0) begin
            if (dy_w == Y_BEG) begin
                sy_d = '0;
                ry_d = '0;
            end else if (in_y) begin
                if (sy_q == SUB_LAST) begin
                    sy_d = '0;
                    if (ry_q != RY_LAST) begin
                        ry_d = ry_q + RYW'(1);
                    end
                end else begin
                    sy_d = sy_q + SYW_ONE();
                end
            end
        end
    end

    function automatic logic [SXW-1:0] SYW_ONE();
        return SXW'(1);
    endfunction

    // ------------------------------------------------------------------
    // Flash control
    // ------------------------------------------------------------------
    logic flash_now;

`ifdef GRID_FLASH_EN
    localparam int FW = FLASH_SHIFT + 1;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // Free-running, wraps naturally from all-ones to zero.
    always_comb begin
        fcnt_d = fcnt_q;
        if (frame_start) begin
            fcnt_d = fcnt_q + FW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign flash_now = fcnt_q[FLASH_SHIFT] & clear_mask[ry_d];
`else
    logic unused_flash_inputs;
    assign unused_flash_inputs = ^{frame_start, clear_mask};
    assign flash_now = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 1: per-pixel decisions
    // ------------------------------------------------------------------
    logic       vld_q, vld_d;
    logic       region_q, region_d;
    logic       line_q, line_d;
    logic [2:0] cell_q, cell_d;
    logic       flash_q, flash_d;

    always_comb begin
        vld_d    = 1'b1;
        region_d = in_x && in_y;
        line_d   = (sx_d == '0) || (sy_d == '0);
        cell_d   = cell_arr[cx_d][ry_d];
        flash_d  = flash_now;
    end

    // ------------------------------------------------------------------
    // Stage 2: palette
    // ------------------------------------------------------------------
    function automatic logic [11:0] palette(input logic [2:0] v);
        case (v)
            3'd0:    return 12'hFFF;
            3'd1:    return 12'h0FF;
            3'd2:    return 12'hFF0;
            3'd3:    return 12'hA0F;
            3'd4:    return 12'h0F0;
            3'd5:    return 12'hF00;
            3'd6:    return 12'h00F;
            default: return 12'hF80;
        endcase
    endfunction

    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = 12'h000;
        if (vld_q && region_q && !line_q) begin
            rgb_d = flash_q ? 12'hFFF : palette(cell_q);
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx_q     <= '0;
            cx_q     <= '0;
            sy_q     <= '0;
            ry_q     <= '0;
            vld_q    <= 1'b0;
            region_q <= 1'b0;
            line_q   <= 1'b0;
            cell_q   <= '0;
            flash_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            sx_q     <= sx_d;
            cx_q     <= cx_d;
            sy_q     <= sy_d;
            ry_q     <= ry_d;
            vld_q    <= vld_d;
            region_q <= region_d;
            line_q   <= line_d;
            cell_q   <= cell_d;
            flash_q  <= flash_d;
            rgb_q    <= rgb_d;
        end
    end

    assign Red   = rgb_q[11:8];
    assign Green = rgb_q[7:4];
    assign Blue  = rgb_q[3:0];

endmodule

// File: tb/tb_grid_renderer.sv
// -----------------------------------------------------------------------------
// tb_grid_renderer
//
// Directed bench for grid_renderer at default parameters. Pixels are driven
// one per clock just after the falling edge; each pixel's expected colour is
// held in a two-deep pending pipe and compared on the falling edge two
// cycles later. Directed expectations are hand-computed constants; the
// full-line sweeps use a divide-based reference model of the playfield.
// Build with +define+GRID_FLASH_EN to exercise the flash path.
// -----------------------------------------------------------------------------
module tb_grid_renderer;

    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int CELL = 24;
    localparam int X0   = 200;
    localparam int Y0   = 0;

    logic                   Clk = 1'b0;
    logic                   Reset_n = 1'b0;
    logic [9:0]             DrawX = '0;
    logic [9:0]             DrawY = '0;
    logic                   frame_start = 1'b0;
    logic [3*COLS*ROWS-1:0] grid = '0;
    logic [ROWS-1:0]        clear_mask = '0;
    logic [3:0]             Red, Green, Blue;

    grid_renderer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .frame_start (frame_start),
        .grid        (grid),
        .clear_mask  (clear_mask),
        .Red         (Red),
        .Green       (Green),
        .Blue        (Blue)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fcnt_tb  = 0;

    logic [11:0] pal_tbl [8] = '{12'hFFF, 12'h0FF, 12'hFF0, 12'hA0F,
                                 12'h0F0, 12'hF00, 12'h00F, 12'hF80};

    logic [11:0] pend_exp [2];
    bit          pend_en  [2];
    string       pend_tag [2];

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%03h exp=%03h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_rgb(input int x, input int y, input int fc);
        int dx, dy, c, r;
        logic [2:0] v;
        if (x < X0 || x >= X0 + COLS * CELL || y < Y0 || y >= Y0 + ROWS * CELL)
            return 12'h000;
        dx = x - X0;
        dy = y - Y0;
        if ((dx % CELL) == 0 || (dy % CELL) == 0)
            return 12'h000;
        c = dx / CELL;
        r = dy / CELL;
`ifdef GRID_FLASH_EN
        if (fc[3] && clear_mask[r])
            return 12'hFFF;
`else
        if (fc < 0)
            return 12'h000;
`endif
        v = grid[(c * ROWS + r) * 3 +: 3];
        return pal_tbl[v];
    endfunction

    task automatic clear_pend();
        pend_en[0] = 1'b0;
        pend_en[1] = 1'b0;
    endtask

    // Present one pixel; compares the pixel presented two calls earlier.
    task automatic drive(input int x, input int y, input bit fs,
                         input bit en, input logic [11:0] exp, input string tag);
        @(negedge Clk);
        if (pend_en[1])
            check_val(pend_tag[1], {Red, Green, Blue}, pend_exp[1]);
        pend_en[1]  = pend_en[0];
        pend_exp[1] = pend_exp[0];
        pend_tag[1] = pend_tag[0];
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        frame_start = fs;
        pend_en[0]  = en;
        pend_exp[0] = exp;
        pend_tag[0] = tag;
    endtask

    // Two idle pixels off-screen (no counter effect) drain the pending pipe.
    task automatic flush(input int y);
        drive(1000, y, 1'b0, 1'b0, 12'h000, "");
        drive(1000, y, 1'b0, 1'b0, 12'h000, "");
    endtask

    task automatic advance_rows(input int y);
        for (int yy = 0; yy < y; yy++)
            drive(0, yy, 1'b0, 1'b0, 12'h000, "");
    endtask

    // Frame from row 0 down to line y, then sweep x = 0..xb on line y,
    // checking every x in [xa, xb] against exp.
    task automatic run_line(input int y, input int xa, input int xb,
                            input logic [11:0] exp, input string tag);
        advance_rows(y);
        for (int xx = 0; xx <= xb; xx++)
            drive(xx, y, 1'b0, (xx >= xa), exp, $sformatf("%s_x%0d", tag, xx));
        flush(y);
        $display("line %s y=%0d x=%0d..%0d exp=%03h", tag, y, xa, xb, exp);
    endtask

    function automatic bit is_swept(input int y);
        int rows [12] = '{0, 1, 10, 23, 24, 25, 240, 455, 456, 470, 479, 480};
        for (int i = 0; i < 12; i++)
            if (rows[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [11:0] exp_flash;
        int          cnt;

        clear_pend();

        // Reset state
        @(negedge Clk);
        check_val("reset_rgb", {Red, Green, Blue}, 12'h000);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // Empty grid, line 30
        run_line(30, 200, 200, 12'h000, "empty_lineleft");
        run_line(30, 201, 201, 12'hFFF, "empty_first");
        run_line(30, 224, 224, 12'h000, "empty_line224");
        run_line(30, 440, 440, 12'h000, "empty_border");
        run_line(30, 441, 441, 12'h000, "empty_outside");
        run_line(30, 199, 199, 12'h000, "empty_left");

        // Asynchronous reset mid-line while the output shows white
        advance_rows(30);
        for (int xx = 0; xx <= 207; xx++)
            drive(xx, 30, 1'b0, 1'b0, 12'h000, "");
        check_val("pre_reset_white", {Red, Green, Blue}, 12'hFFF);
        #2 Reset_n = 1'b0;
        #1 check_val("async_reset_black", {Red, Green, Blue}, 12'h000);
        clear_pend();
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check_val("refill_black", {Red, Green, Blue}, 12'h000);
        run_line(30, 201, 203, 12'hFFF, "post_reset");

        // Cell lookup: grid[3][1] = 5
        grid[(3 * ROWS + 1) * 3 +: 3] = 3'd5;
        run_line(30, 273, 295, 12'hF00, "cell_red");
        run_line(30, 272, 272, 12'h000, "cell_left_line");
        run_line(30, 296, 296, 12'h000, "cell_right_line");
        run_line(30, 297, 297, 12'hFFF, "cell_next");

        // Row tracking: grid[0][19] = 2
        grid = '0;
        grid[(0 * ROWS + 19) * 3 +: 3] = 3'd2;
        run_line(470, 210, 210, 12'hFF0, "row19_yellow");
        run_line(456, 210, 210, 12'h000, "row19_line");

        // Flash: grid[0][0] = 1 with row 0 pending clear
        grid = '0;
        grid[0 +: 3] = 3'd1;
        clear_mask = '0;
        clear_mask[0] = 1'b1;
        for (int f = 0; f <= 16; f++) begin
`ifdef GRID_FLASH_EN
            exp_flash = (f >= 8 && f < 16) ? 12'hFFF : 12'h0FF;
`else
            exp_flash = 12'h0FF;
`endif
            run_line(10, 210, 210, exp_flash, $sformatf("flash_f%0d", f));
            // frame_start lands on a row-update cycle
            drive(0, 0, 1'b1, 1'b0, 12'h000, "");
            fcnt_tb++;
        end
        // Move the frame counter into the flashing half-period
        while (fcnt_tb[3] == 1'b0) begin
            drive(0, 0, 1'b1, 1'b0, 12'h000, "");
            fcnt_tb++;
        end
        drive(1000, 0, 1'b0, 1'b0, 12'h000, "");

        // Random grid, sparse full-frame sweep against the reference model
        for (int i = 0; i < COLS * ROWS; i++)
            grid[i * 3 +: 3] = 3'($urandom_range(0, 7));
        clear_mask = ROWS'($urandom);
        for (int y = 0; y <= 480; y++) begin
            if (is_swept(y)) begin
                cnt = 0;
                for (int xx = 0; xx <= 450; xx++) begin
                    drive(xx, y, 1'b0, 1'b1, ref_rgb(xx, y, fcnt_tb),
                          $sformatf("sweep_y%0d_x%0d", y, xx));
                    cnt++;
                end
                flush(y);
                $display("sweep y=%0d pixels=%0d", y, cnt);
            end else begin
                drive(0, y, 1'b0, 1'b0, 12'h000, "");
            end
        end
        flush(480);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
